// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg
// Shared definitions for the input debouncer: the qualification FSM state
// encoding and the legal synchronizer depth range.
package sync_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

endpackage : sync_debounce_pkg

// File: rtl/sync_chain.sv
// sync_chain
// N-flop metastability synchronizer with asynchronous active-low reset.
// Reusable at any single-bit clock-domain-crossing point.
//
// Ports:
//   clk   in   sampling clock, rising edge
//   rstn  in   asynchronous active-low reset, clears every stage
//   d     in   asynchronous input bit
//   q     out  synchronized output (last stage)
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < N; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[N-1];

endmodule : sync_chain

// File: rtl/sync_debounce.sv
// sync_debounce
// Conditions one asynchronous, possibly bouncing input: a flop-chain
// synchronizer followed by a counter-qualified FSM that only accepts a new
// level after DEBOUNCE_CYCLES consecutive stable synchronized samples.
//
// Ports:
//   clk         in   system clock, rising edge
//   rstn        in   asynchronous active-low reset
//   async_in    in   raw asynchronous input
//   en          in   debounce enable; low freezes the accepted level
//   level_out   out  debounced accepted level (registered)
//   rise_pulse  out  one-cycle strobe on level_out 0->1 (registered)
//   fall_pulse  out  one-cycle strobe on level_out 1->0 (registered)
//   busy        out  high while a candidate level is being qualified
//   state_dbg   out  current FSM state, for observation
//
// Handshake: none; async_in is a free-running level, outputs are levels and
// single-cycle strobes with no back-pressure.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   async_in,
    input  logic   en,
    output logic   level_out,
    output logic   rise_pulse,
    output logic   fall_pulse,
    output logic   busy,
    output state_t state_dbg
);

    // Reject illegal parameterizations at elaboration.
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
        $error("sync_debounce: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("sync_debounce: CNT_W=%0d outside 1..32", CNT_W);
    end
    if (longint'(DEBOUNCE_CYCLES) < 64'sd1 ||
        longint'(DEBOUNCE_CYCLES) > ((64'sd1 <<< CNT_W) - 64'sd1)) begin : g_bad_cycles
        $error("sync_debounce: DEBOUNCE_CYCLES=%0d outside 1..2^CNT_W-1", DEBOUNCE_CYCLES);
    end

    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               DEB_ONE = (DEBOUNCE_CYCLES == 1);

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (async_in),
        .q    (s)
    );

    // cnt is always below DEB_C in a QUAL state, so the increment cannot wrap.
    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (!en) begin
                // Abandon any candidate; the accepted level holds.
                state <= level_out ? STABLE_HI : STABLE_LO;
                cnt   <= '0;
            end else begin
                case (state)
                    STABLE_LO: begin
                        if (s) begin
                            if (DEB_ONE) begin
                                state      <= STABLE_HI;
                                level_out  <= 1'b1;
                                rise_pulse <= 1'b1;
                            end else begin
                                state <= QUAL_HI;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    QUAL_HI: begin
                        if (!s) begin
                            state <= STABLE_LO;
                            cnt   <= '0;
                        end else if (cnt_inc == DEB_C) begin
                            state      <= STABLE_HI;
                            cnt        <= '0;
                            level_out  <= 1'b1;
                            rise_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    STABLE_HI: begin
                        if (!s) begin
                            if (DEB_ONE) begin
                                state      <= STABLE_LO;
                                level_out  <= 1'b0;
                                fall_pulse <= 1'b1;
                            end else begin
                                state <= QUAL_LO;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    QUAL_LO: begin
                        if (s) begin
                            state <= STABLE_HI;
                            cnt   <= '0;
                        end else if (cnt_inc == DEB_C) begin
                            state      <= STABLE_LO;
                            cnt        <= '0;
                            level_out  <= 1'b0;
                            fall_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= level_out ? STABLE_HI : STABLE_LO;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy      = (state == QUAL_HI) || (state == QUAL_LO);
    assign state_dbg = state;

endmodule : sync_debounce

// File: doc/sync_debounce.md
# sync_debounce

Conditions one asynchronous, possibly bouncing input (push-button, switch, external strobe) for the synchronous logic. It sits directly downstream of the reset-capable D flip-flop primitive and builds on it:
- A chain of those flops forms the metastability synchronizer.
- A counter-qualified state machine accepts only levels that stay stable.
- Outputs are a clean registered level plus one-cycle rise and fall pulses for downstream control logic.

## Interface
- SYNC_STAGES, default 2: number of synchronizer flops; legal range 2..4.
- CNT_W, default 16: width of the stability counter.
- DEBOUNCE_CYCLES, default 1000: number of consecutive stable synchronized samples needed to accept a new level. Legal range is 1..2^CNT_W-1; any other value must cause an elaboration error.

- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- async_in  in  1  raw asynchronous input; no timing relation to clk.
- en  in  1  debounce enable; when low, the accepted level is frozen.
- level_out  out  1  debounced, accepted level.
- rise_pulse  out  1  one-cycle strobe when level_out goes 0->1.
- fall_pulse  out  1  one-cycle strobe when level_out goes 1->0.
- busy  out  1  high while a candidate level change is being qualified.

## Operation
- **Synchronizer.** A SYNC_STAGES-deep flop chain samples async_in. The last stage is called s. All stages reset to 0. The chain runs regardless of en.
- **FSM states:**
  - STABLE_LO: level_out=0.
  - QUAL_HI: candidate 1, level_out=0.
  - STABLE_HI: level_out=1.
  - QUAL_LO: candidate 0, level_out=1.
- **Transitions, evaluated each rising edge with en=1:**
  - STABLE_LO with s=1 -> QUAL_HI, cnt=1.
  - QUAL_HI with s=1 -> cnt++. When cnt reaches DEBOUNCE_CYCLES -> STABLE_HI, level_out<=1, rise_pulse<=1.
  - QUAL_HI with s=0 -> STABLE_LO, cnt=0 (bounce rejected).
  - The same rules apply symmetrically for STABLE_HI / QUAL_LO / fall_pulse.
  - DEBOUNCE_CYCLES=1: STABLE_x goes directly to the opposite STABLE state on the first differing sample. QUAL states are skipped and busy never asserts.
- **Counter rules.** cnt never exceeds DEBOUNCE_CYCLES, so there is no wrap. The comparison is done at CNT_W width.
- **Disable.** en=0 at an edge forces the FSM to the STABLE state matching the current level_out and clears cnt. No pulses are produced. When en returns high, qualification restarts from zero.
- **Output coding.**
  - busy = state is QUAL_HI or QUAL_LO.
  - rise_pulse and fall_pulse are registered. They are never high together and never high for two consecutive cycles.
- **Reset.** rstn low at any time, including mid-qualification, immediately clears:
  - sync chain = 0
  - state = STABLE_LO
  - cnt = 0
  - level_out = 0, rise_pulse = 0, fall_pulse = 0, busy = 0
- **Input high at reset release.** If async_in is high when rstn releases, it is qualified as a normal 0->1 change and produces one rise_pulse.

## Timing
- **Latency.** Count edges from the first rising edge that samples the new stable async_in value as edge 1. level_out and the pulse update on edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults: edge 1002. With SYNC_STAGES=2, DEBOUNCE_CYCLES=4: edge 6.
- **Pulse alignment.** The pulse is high for exactly the cycle following that edge, coincident with the first cycle of the new level_out.
- **Bounce rejection.** A glitch on s shorter than DEBOUNCE_CYCLES samples produces no output change. Qualification restarts on the next differing sample.
- **Reset timing.** Assertion acts without a clock. Deassertion is expected to be synchronized externally; this block applies no reset synchronization.

## Structure
- **Shared package sync_debounce_pkg:**
  - state enum (STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO)
  - constants MIN_SYNC_STAGES=2 and MAX_SYNC_STAGES=4
- **Sub-module sync_chain:** parameterized N-flop synchronizer with asynchronous active-low reset. It is reusable by other clock-domain-crossing points.
- **Top-level contents:** sync_chain instance, FSM, counter and output registers.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=4.
- **Reset values.** Hold rstn=0 with async_in=1 for 5 cycles -> level_out, rise_pulse, fall_pulse and busy all stay 0. After release, rise_pulse fires once, on edge 6 counted from the first edge after release.
- **Clean rise.** Drive async_in 0->1 and hold -> busy is high from edge 3 to edge 5, level_out=1 from edge 6, and rise_pulse is high for exactly one cycle after edge 6.
- **Bounce.** Drive async_in high for 3 cycles, low for 2, then high steadily -> no pulse from the 3-cycle burst. level_out rises on the 6th edge of the final high period.
- **Fall and alternation.** Drive a stable high, then stable low -> one fall_pulse. rise_pulse and fall_pulse never overlap.
- **Disable mid-qualification.** Drop en for 2 cycles during QUAL_HI -> no pulse and level_out stays 0. After en returns high, qualification needs 4 fresh samples.
- **Reset mid-qualification.** Assert rstn mid-QUAL_LO -> outputs clear immediately without waiting for a clock edge.
